error_stream_multi: RTL and testbench
=====================================

# error_stream_multi

Parametrised multi-channel error-pattern generator for the QEC decoder test harness. One xoroshiro128+ PRNG, one draw per cycle, fills a frame of NUM_CHANNELS × MEASUREMENT_ROUNDS error bits against a run-time error threshold. Completed frames go out over a valid/ready handshake with a popcount and frame number. A new frame fills while the previous one waits for the consumer.

## Interface
- NUM_CHANNELS, 4, independent error channels per round (≥1)
- MEASUREMENT_ROUNDS, 5, rounds per frame (≥1)
- THRESHOLD_WIDTH, 16, width of threshold compare on r[63 -: THRESHOLD_WIDTH] (1..32)
- Derived: TOTAL = NUM_CHANNELS*MEASUREMENT_ROUNDS; CNT_W = $clog2(TOTAL+1)
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- s0_initial  in  64  PRNG seed word 0, sampled in SEED state
- s1_initial  in  64  PRNG seed word 1, sampled in SEED state
- error_threshold  in  THRESHOLD_WIDTH  error iff r[63 -: THRESHOLD_WIDTH] < threshold; latched at frame start
- enable  in  1  FILL advances only when high
- error_valid  out  1  frame held on outputs
- error_ready  in  1  consumer accepts frame when valid&ready
- error_stream  out  TOTAL  bit k = round (k / NUM_CHANNELS), channel (k % NUM_CHANNELS)
- error_count  out  CNT_W  popcount of error_stream
- frame_id  out  16  frame number, starts at 0, wraps at 16'hFFFF→0

## Operation
- States: SEED, FILL, STALL.
- Reset (async, reset_n=0):
  - state=SEED, PRNG state=0, fill index=0.
  - error_valid=0, error_stream=0, error_count=0, frame_id=0.
  - Internal next-frame id=0.
- SEED, one cycle:
  - Load s0/s1 into the PRNG.
  - Latch threshold.
  - Go to FILL.
- FILL, when enable=1, each cycle:
  - Capture the compare result of current r into buffer bit k.
  - Add it to the running count.
  - Advance the PRNG.
  - k++.
- FILL, enable=0: nothing changes.
- Last bit (k=TOTAL-1), output slot free (error_valid=0, or error_ready=1 this cycle):
  - Transfer buffer+last bit, count and next id to the outputs.
  - Set error_valid=1.
  - Increment next id, k=0, relatch threshold.
  - Stay in FILL.
- Last bit, slot occupied:
  - Write the last bit into the buffer.
  - Go to STALL with the PRNG advanced.
- STALL:
  - PRNG frozen, buffer held.
  - When error_ready=1: transfer as above, go to FILL with k=0.
- Handshake:
  - error_valid&error_ready with no simultaneous transfer → error_valid=0 next cycle.
  - Accept and transfer in the same cycle → valid stays 1 and the new frame appears. No bubble, no frame lost or duplicated.
  - Outputs stable while error_valid=1 && error_ready=0.
- Threshold:
  - 0 → all bits 0.
  - Mid-frame threshold changes take effect only at the next frame.
- PRNG: r = s0+s1 (mod 2^64); standard xoroshiro128+ (24,16,37) update.

## Timing
- Reset release → first valid frame on the (TOTAL+1)th rising edge, given enable=1 throughout: 1 SEED + TOTAL FILL cycles.
- Steady state, error_ready=1 and enable=1: one frame every TOTAL cycles.
- STALL exit: new frame visible the edge after error_ready=1 is sampled.
- reset_n asserted mid-FILL or mid-STALL: all outputs to reset values immediately, partial frame discarded, restart from SEED.

## Structure
- Package error_stream_pkg:
  - xoroshiro rotate constants (24, 16, 37).
  - State enum {SEED, FILL, STALL}.
  - Default parameter values.
- Sub-module xoroshiro128p_core:
  - Inputs: clk, reset_n, load, s0_in, s1_in, step.
  - Output: r, combinational from state.
  - load has priority over step.

## Test plan
- Seeds s0=1, s1=2, threshold=1, ready=1: first r=3, so bit0=1. Remaining bits match the golden model. frame_id=0 on the 21st edge (default params).
- threshold=0, 3 frames: error_stream=0, error_count=0, frame_id 0,1,2 every 20 cycles.
- ready low for 60 cycles, then high:
  - Frame 0 held stable.
  - Generator sits in STALL after frame 1 completes.
  - On release, frames 1 and 2 follow with consecutive ids and no gap.
- enable toggled 1/0 each cycle: first frame after 41 edges, contents identical to the enable-always run.
- threshold changed 0→16'hFFFF at k=7: the current frame has no errors; the next frame follows the model with 16'hFFFF.
- reset_n pulsed low at k=10 of frame 2: outputs reset asynchronously. Rerun reproduces frame 0 bit-exactly.

Source files
------------

// File: rtl/error_stream_pkg.sv
// rtl/error_stream_pkg.sv - shared types, constants and helpers for the error stream generator
package error_stream_pkg;

  // xoroshiro128+ rotate/shift constants (a, b, c)
  localparam int ROT_A   = 24;
  localparam int SHIFT_B = 16;
  localparam int ROT_C   = 37;

  // default geometry of the generator
  localparam int DEF_NUM_CHANNELS       = 4;
  localparam int DEF_MEASUREMENT_ROUNDS = 5;
  localparam int DEF_THRESHOLD_WIDTH    = 16;

  typedef enum logic [1:0] {
    SEED  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } state_t;

  // 64-bit rotate left by a constant amount
  function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

endpackage

// File: rtl/xoroshiro128p_core.sv
// rtl/xoroshiro128p_core.sv - xoroshiro128+ PRNG state with load-over-step priority
module xoroshiro128p_core
  import error_stream_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [63:0] s0_in,
  input  logic [63:0] s1_in,
  input  logic        step,
  output logic [63:0] r
);

  logic [63:0] s0;
  logic [63:0] s1;
  logic [63:0] t;

  // output is the sum of the two state words, valid before the step
  assign r = s0 + s1;
  assign t = s1 ^ s0;

  // seed load wins over a step; otherwise advance one draw when asked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0 <= '0;
      s1 <= '0;
    end else if (load) begin
      s0 <= s0_in;
      s1 <= s1_in;
    end else if (step) begin
      s0 <= rotl64(s0, ROT_A) ^ t ^ (t << SHIFT_B);
      s1 <= rotl64(t, ROT_C);
    end
  end

endmodule

// File: rtl/error_stream_multi.sv
// rtl/error_stream_multi.sv - multi-channel error frame generator with valid/ready output
module error_stream_multi
  import error_stream_pkg::*;
#(
  parameter int NUM_CHANNELS       = DEF_NUM_CHANNELS,
  parameter int MEASUREMENT_ROUNDS = DEF_MEASUREMENT_ROUNDS,
  parameter int THRESHOLD_WIDTH    = DEF_THRESHOLD_WIDTH
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic [63:0]                                           s0_initial,
  input  logic [63:0]                                           s1_initial,
  input  logic [THRESHOLD_WIDTH-1:0]                            error_threshold,
  input  logic                                                  enable,
  output logic                                                  error_valid,
  input  logic                                                  error_ready,
  output logic [NUM_CHANNELS*MEASUREMENT_ROUNDS-1:0]            error_stream,
  output logic [$clog2(NUM_CHANNELS*MEASUREMENT_ROUNDS+1)-1:0]  error_count,
  output logic [15:0]                                           frame_id
);

  localparam int TOTAL = NUM_CHANNELS * MEASUREMENT_ROUNDS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  state_t                     state;
  logic [IDX_W-1:0]           k;
  logic [TOTAL-1:0]           buffer;
  logic [CNT_W-1:0]           count;
  logic [THRESHOLD_WIDTH-1:0] thr;
  logic [15:0]                next_id;

  logic [63:0]                r;
  logic                       hit;
  logic                       last;
  logic                       slot_free;
  logic                       fill_go;
  logic [TOTAL-1:0]           hit_mask;
  logic [CNT_W-1:0]           hit_inc;
  logic                       unused_r;

  // only the top bits of each draw take part in the compare
  assign unused_r  = ^r;
  assign hit       = r[63 -: THRESHOLD_WIDTH] < thr;
  assign last      = (k == IDX_W'(TOTAL - 1));
  assign slot_free = !error_valid || error_ready;
  assign fill_go   = (state == FILL) && enable;
  assign hit_inc   = CNT_W'(hit);

  // place the current compare result at its frame position
  always_comb begin
    hit_mask    = '0;
    hit_mask[k] = hit;
  end

  xoroshiro128p_core u_prng (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state == SEED),
    .s0_in   (s0_initial),
    .s1_in   (s1_initial),
    .step    (fill_go),
    .r       (r)
  );

  // frame fill, stall and output handshake state machine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= SEED;
      k            <= '0;
      buffer       <= '0;
      count        <= '0;
      thr          <= '0;
      next_id      <= '0;
      error_valid  <= 1'b0;
      error_stream <= '0;
      error_count  <= '0;
      frame_id     <= '0;
    end else begin
      // a consumed frame drops valid unless a new one lands this same cycle
      if (error_valid && error_ready) begin
        error_valid <= 1'b0;
      end
      case (state)
        SEED: begin
          thr    <= error_threshold;
          k      <= '0;
          buffer <= '0;
          count  <= '0;
          state  <= FILL;
        end
        FILL: begin
          if (enable) begin
            if (last && slot_free) begin
              error_stream <= buffer | hit_mask;
              error_count  <= count + hit_inc;
              frame_id     <= next_id;
              error_valid  <= 1'b1;
              next_id      <= next_id + 16'd1;
              k            <= '0;
              buffer       <= '0;
              count        <= '0;
              thr          <= error_threshold;
            end else if (last) begin
              buffer <= buffer | hit_mask;
              count  <= count + hit_inc;
              state  <= STALL;
            end else begin
              buffer <= buffer | hit_mask;
              count  <= count + hit_inc;
              k      <= k + IDX_W'(1);
            end
          end
        end
        STALL: begin
          if (error_ready) begin
            error_stream <= buffer;
            error_count  <= count;
            frame_id     <= next_id;
            error_valid  <= 1'b1;
            next_id      <= next_id + 16'd1;
            k            <= '0;
            buffer       <= '0;
            count        <= '0;
            thr          <= error_threshold;
            state        <= FILL;
          end
        end
        default: begin
          state <= SEED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_error_stream_multi.sv
// tb/tb_error_stream_multi.sv - randomized scoreboard bench for error_stream_multi
module tb_error_stream_multi;

  localparam int NC    = 4;
  localparam int MR    = 5;
  localparam int TW    = 16;
  localparam int TOTAL = NC * MR;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef struct packed {
    logic [TOTAL-1:0] stream;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      id;
  } frame_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [63:0]      s0_initial;
  logic [63:0]      s1_initial;
  logic [TW-1:0]    error_threshold;
  logic             enable;
  logic             error_valid;
  logic             error_ready;
  logic [TOTAL-1:0] error_stream;
  logic [CNT_W-1:0] error_count;
  logic [15:0]      frame_id;

  frame_t exp_q[$];
  int     acc_cyc[$];
  int     compared   = 0;
  int     mismatched = 0;
  int     cyc        = 0;
  int     acc_count  = 0;
  logic   prev_hold  = 1'b0;
  frame_t prev_f;

  error_stream_multi #(
    .NUM_CHANNELS       (NC),
    .MEASUREMENT_ROUNDS (MR),
    .THRESHOLD_WIDTH    (TW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .s0_initial      (s0_initial),
    .s1_initial      (s1_initial),
    .error_threshold (error_threshold),
    .enable          (enable),
    .error_valid     (error_valid),
    .error_ready     (error_ready),
    .error_stream    (error_stream),
    .error_count     (error_count),
    .frame_id        (frame_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the draw sequence r_i of xoroshiro128+ is consumed TOTAL at a time per frame.
  task automatic push_frames(input logic [63:0] s0, input logic [63:0] s1, input int n,
                             input logic [15:0] thr_first, input logic [15:0] thr_rest);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sum;
    logic [63:0] na;
    logic [15:0] th;
    frame_t      f;
    a = s0;
    b = s1;
    for (int fi = 0; fi < n; fi++) begin
      f.stream = '0;
      f.cnt    = '0;
      f.id     = 16'(fi);
      th       = (fi == 0) ? thr_first : thr_rest;
      for (int kk = 0; kk < TOTAL; kk++) begin
        sum = a + b;
        if (sum[63:48] < th) begin
          f.stream[kk] = 1'b1;
          f.cnt        = f.cnt + 1'b1;
        end
        b  = b ^ a;
        na = {a[39:0], a[63:40]} ^ b ^ (b << 16);
        a  = na;
        b  = {b[26:0], b[63:27]};
      end
      exp_q.push_back(f);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted frame and checks held outputs stay put.
  always @(negedge clk) begin
    frame_t f;
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", error_valid, 1'b1);
        chk("hold_stream", error_stream, prev_f.stream);
        chk("hold_count", error_count, prev_f.cnt);
        chk("hold_id", frame_id, prev_f.id);
      end
      if (error_valid && error_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_frame: got id %0h expected no frame", frame_id);
        end else begin
          f = exp_q.pop_front();
          chk("frame_stream", error_stream, f.stream);
          chk("frame_count", error_count, f.cnt);
          chk("frame_id", frame_id, f.id);
        end
        acc_count++;
        acc_cyc.push_back(cyc);
      end
      prev_hold     = error_valid && !error_ready;
      prev_f.stream = error_stream;
      prev_f.cnt    = error_count;
      prev_f.id     = frame_id;
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", error_valid, 1'b0);
    chk("reset_stream", error_stream, '0);
    chk("reset_count", error_count, '0);
    chk("reset_id", frame_id, '0);
    exp_q.delete();
    acc_cyc.delete();
    acc_count = 0;
  endtask

  task automatic wait_accepts(input int n, input int budget);
    int c;
    c = 0;
    while (acc_count < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("accept_count", acc_count, n);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int          edges;
    logic [63:0] rs0;
    logic [63:0] rs1;
    logic [15:0] rth;

    reset_n         = 1'b0;
    enable          = 1'b1;
    error_ready     = 1'b1;
    s0_initial      = '0;
    s1_initial      = '0;
    error_threshold = '0;

    // fixed seeds 1/2, threshold 1: first draw is 3, so bit 0 is set
    s0_initial      = 64'd1;
    s1_initial      = 64'd2;
    error_threshold = 16'd1;
    apply_reset();
    push_frames(64'd1, 64'd2, 3, 16'd1, 16'd1);
    reset_n = 1'b1;
    edges = 0;
    while (!error_valid && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("first_valid_edge", edges, 21);
    chk("first_bit0", error_stream[0], 1'b1);
    wait_accepts(3, 200);

    // threshold 0: empty frames, one every TOTAL cycles
    rs0 = {$urandom(), $urandom()};
    rs1 = {$urandom(), $urandom()};
    s0_initial      = rs0;
    s1_initial      = rs1;
    error_threshold = 16'd0;
    apply_reset();
    push_frames(rs0, rs1, 3, 16'd0, 16'd0);
    reset_n = 1'b1;
    wait_accepts(3, 200);
    if (acc_cyc.size() >= 3) begin
      chk("interval_0_1", acc_cyc[1] - acc_cyc[0], TOTAL);
      chk("interval_1_2", acc_cyc[2] - acc_cyc[1], TOTAL);
    end

    // consumer stalls 60 cycles: frame 0 held, generator parks after frame 1
    rs0 = {$urandom(), $urandom()};
    rs1 = {$urandom(), $urandom()};
    rth = 16'($urandom_range(0, 65535));
    s0_initial      = rs0;
    s1_initial      = rs1;
    error_threshold = rth;
    apply_reset();
    push_frames(rs0, rs1, 3, rth, rth);
    error_ready = 1'b0;
    reset_n     = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("stall_valid", error_valid, 1'b1);
    chk("stall_id", frame_id, 16'd0);
    error_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_no_bubble", error_valid, 1'b1);
    chk("release_next_id", frame_id, 16'd1);
    wait_accepts(3, 100);

    // enable toggling every cycle doubles the fill time, contents unchanged
    s0_initial      = 64'd1;
    s1_initial      = 64'd2;
    error_threshold = 16'd1;
    apply_reset();
    push_frames(64'd1, 64'd2, 1, 16'd1, 16'd1);
    enable  = 1'b1;
    reset_n = 1'b1;
    edges   = 0;
    while (!error_valid && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
      enable = ((edges + 1) % 2) == 1;
    end
    chk("toggle_first_valid_edge", edges, 41);
    wait_accepts(1, 10);
    enable = 1'b1;

    // threshold raised mid-frame only affects the following frame
    rs0 = {$urandom(), $urandom()};
    rs1 = {$urandom(), $urandom()};
    s0_initial      = rs0;
    s1_initial      = rs1;
    error_threshold = 16'd0;
    apply_reset();
    push_frames(rs0, rs1, 2, 16'd0, 16'hFFFF);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    error_threshold = 16'hFFFF;
    wait_accepts(2, 100);

    // asynchronous reset at k=10 of frame 2, then a rerun reproduces frame 0
    rs0 = {$urandom(), $urandom()};
    rs1 = {$urandom(), $urandom()};
    rth = 16'($urandom_range(0, 65535));
    s0_initial      = rs0;
    s1_initial      = rs1;
    error_threshold = rth;
    apply_reset();
    push_frames(rs0, rs1, 3, rth, rth);
    error_ready = 1'b1;
    reset_n     = 1'b1;
    repeat (22) @(posedge clk);
    #1;
    error_ready = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    chk("pre_reset_accepts", acc_count, 1);
    chk("pre_reset_valid", error_valid, 1'b1);
    chk("pre_reset_id", frame_id, 16'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_valid", error_valid, 1'b0);
    chk("async_reset_stream", error_stream, '0);
    chk("async_reset_count", error_count, '0);
    chk("async_reset_id", frame_id, '0);
    apply_reset();
    push_frames(rs0, rs1, 1, rth, rth);
    error_ready = 1'b1;
    reset_n     = 1'b1;
    wait_accepts(1, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
